// File: rtl/regfile.sv
// 32 x 32-bit RV32I integer register file. Two combinational read ports and
// one write port clocked on the rising edge. Register x0 always reads zero.
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chip_en,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] regNum0,
  output logic [DATA_WIDTH-1:0] dataOut0,
  input  logic [ADDR_WIDTH-1:0] regNum1,
  output logic [DATA_WIDTH-1:0] dataOut1,
  input  logic [ADDR_WIDTH-1:0] wRegNum,
  input  logic [DATA_WIDTH-1:0] wDataIn
);

  logic [DATA_WIDTH-1:0] reg_mem [0:NUM_REGS-1];
  logic                  writeHit;

  // A write needs the block enabled, the write strobe, and a non-x0 target.
  assign writeHit = chip_en && writeEnable && (wRegNum != '0);

  // reg_mem[0] is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_mem[i] <= '0;
      end
    end else if (writeHit) begin
      reg_mem[wRegNum] <= wDataIn;
    end
  end

  // Reads have no write bypass: a same-cycle write shows up after the edge.
  assign dataOut0 = (regNum0 == '0) ? '0 : reg_mem[regNum0];
  assign dataOut1 = (regNum1 == '0) ? '0 : reg_mem[regNum1];

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed reset/write sweeps, a vector table, async reset
// and read-during-write sequences, and a randomized run against an array model.
module tb_regfile;

  logic        clk;
  logic        reset;
  logic        chip_en;
  logic        writeEnable;
  logic [4:0]  regNum0;
  logic [31:0] dataOut0;
  logic [4:0]  regNum1;
  logic [31:0] dataOut1;
  logic [4:0]  wRegNum;
  logic [31:0] wDataIn;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [0:31];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        ce;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [0:7];

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .clk(clk),
    .reset(reset),
    .chip_en(chip_en),
    .writeEnable(writeEnable),
    .regNum0(regNum0),
    .dataOut0(dataOut0),
    .regNum1(regNum1),
    .dataOut1(dataOut1),
    .wRegNum(wRegNum),
    .wDataIn(wDataIn)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ce, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1);
    chip_en     = ce;
    writeEnable = we;
    wRegNum     = wr;
    wDataIn     = wd;
    regNum0     = r0;
    regNum1     = r1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 32; k++) model[k] = '0;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : model[r];
  endfunction

  task automatic pop_chk(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %h expected <empty queue>", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, act, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int k = 0; k < 32; k++) model[k] = '0;

    // reset state
    tick();
    for (int j = 1; j < 32; j++) chk($sformatf("reset_mem[%0d]", j), dut.reg_mem[j], 32'd0);
    regNum0 = 5'd17; regNum1 = 5'd31; #1;
    chk("reset_out0", dataOut0, 32'd0);
    chk("reset_out1", dataOut1, 32'd0);
    reset = 1'b0;
    #1;

    // single-register write sweep, then hold with writes disabled
    for (int i = 1; i < 32; i++) begin
      do_reset();
      drive(1'b1, 1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
      tick();
      for (int j = 0; j < 32; j++)
        chk($sformatf("sweep%0d_mem[%0d]", i, j), dut.reg_mem[j], (j == i) ? 32'(i) : 32'd0);
      drive(1'b1, 1'b0, 5'(i), 32'hF0F0F0F0, 5'(i), 5'(i));
      tick();
      chk($sformatf("hold%0d_out0", i), dataOut0, 32'(i));
      chk($sformatf("hold%0d_out1", i), dataOut1, 32'(i));
      chk($sformatf("hold%0d_mem", i), dut.reg_mem[i], 32'(i));
    end

    // vector table, applied from a fresh reset; expectations are after the edge
    vecs[0] = '{1'b1, 1'b1, 5'd3,  32'h11111111, 5'd3,  5'd3,  32'h11111111, 32'h11111111};
    vecs[1] = '{1'b1, 1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd3,  32'h00000000, 32'h11111111};
    vecs[2] = '{1'b0, 1'b1, 5'd5,  32'h00001234, 5'd5,  5'd3,  32'h00000000, 32'h11111111};
    vecs[3] = '{1'b1, 1'b0, 5'd5,  32'h00001234, 5'd5,  5'd0,  32'h00000000, 32'h00000000};
    vecs[4] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd3,  32'hFFFFFFFF, 32'h11111111};
    vecs[5] = '{1'b1, 1'b1, 5'd3,  32'h22222222, 5'd3,  5'd31, 32'h22222222, 32'hFFFFFFFF};
    vecs[6] = '{1'b1, 1'b1, 5'd1,  32'h00000001, 5'd1,  5'd2,  32'h00000001, 32'h00000000};
    vecs[7] = '{1'b0, 1'b0, 5'd1,  32'hAAAAAAAA, 5'd0,  5'd1,  32'h00000000, 32'h00000001};
    do_reset();
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].ce, vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].r0, vecs[v].r1);
      tick();
      chk($sformatf("vec%0d_out0", v), dataOut0, vecs[v].exp0);
      chk($sformatf("vec%0d_out1", v), dataOut1, vecs[v].exp1);
    end
    chk("vec_x0_mem", dut.reg_mem[0], 32'd0);

    // read during write to same index: old value before edge, new after
    do_reset();
    drive(1'b1, 1'b1, 5'd9, 32'h0000000A, 5'd9, 5'd9);
    tick();
    drive(1'b1, 1'b1, 5'd9, 32'h0000000B, 5'd9, 5'd9);
    #1;
    chk("rdw_before_edge", dataOut0, 32'h0000000A);
    tick();
    chk("rdw_after_edge0", dataOut0, 32'h0000000B);
    chk("rdw_after_edge1", dataOut1, 32'h0000000B);

    // async reset mid-cycle clears before the next edge, and blocks writes
    drive(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd9);
    tick();
    chk("pre_async_mem7", dut.reg_mem[7], 32'hA5A5A5A5);
    drive(1'b1, 1'b1, 5'd7, 32'h5A5A5A5A, 5'd7, 5'd9);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_mem7", dut.reg_mem[7], 32'd0);
    chk("async_out0", dataOut0, 32'd0);
    chk("async_out1", dataOut1, 32'd0);
    tick();
    chk("reset_blocks_write", dut.reg_mem[7], 32'd0);
    // release mid-cycle; the pending write lands at the next edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release_no_write_yet", dataOut0, 32'd0);
    tick();
    chk("first_write_after_release", dataOut0, 32'h5A5A5A5A);

    // randomized run against the array model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic        ce, we;
      logic [4:0]  wr, r0, r1;
      logic [31:0] wd;
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        #1;
        for (int k = 0; k < 32; k++) model[k] = '0;
        reset = 1'b0;
        #1;
      end
      ce = ($urandom_range(0, 7) != 0);
      we = ($urandom_range(0, 3) != 0);
      wr = 5'($urandom_range(0, 31));
      wd = $urandom;
      r0 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 31));
      drive(ce, we, wr, wd, r0, r1);
      #1;
      exp_q.push_back(model_read(r0));
      exp_q.push_back(model_read(r1));
      pop_chk($sformatf("rnd%0d_pre0", n), dataOut0);
      pop_chk($sformatf("rnd%0d_pre1", n), dataOut1);
      if (ce && we && wr != 5'd0) model[wr] = wd;
      tick();
      exp_q.push_back(model_read(r0));
      exp_q.push_back(model_read(r1));
      pop_chk($sformatf("rnd%0d_post0", n), dataOut0);
      pop_chk($sformatf("rnd%0d_post1", n), dataOut1);
    end
    for (int j = 0; j < 32; j++) chk($sformatf("final_mem[%0d]", j), dut.reg_mem[j], model_read(5'(j)));

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
